// File: rtl/riscv_perf_counters_v2.sv
// Performance-monitor unit: N_CNT event counters with per-counter event
// selectors, wrap/saturate overflow, sticky overflow status with a maskable
// interrupt, and a shared high-word shadow for tear-free 64-bit reads.
module riscv_perf_counters_v2 #(
    parameter int N_CNT     = 4,
    parameter int N_EVENTS  = 16,
    parameter int CNT_WIDTH = 48,
    parameter int EVT_SEL_W = $clog2(N_EVENTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [1:0]          csr_op_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] events_i,
    output logic                ovf_irq_o
);

    localparam int HI_W = CNT_WIDTH - 32;
    // One extra selector bit so that values >= N_EVENTS are stored as written
    // and can be used to park a counter.
    localparam int SEL_W = EVT_SEL_W + 1;
    localparam logic [4:0] N_CNT_L = 5'(N_CNT);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                              input logic [31:0] w,
                                              input logic [31:0] q);
        case (op)
            OP_WRITE: csr_apply = w;
            OP_SET:   csr_apply = w | q;
            OP_CLEAR: csr_apply = ~w & q;
            default:  csr_apply = q;
        endcase
    endfunction

    // Returns {overflow, next value}; at all-ones either wraps to zero or holds.
    function automatic logic [CNT_WIDTH:0] cnt_step(input logic [CNT_WIDTH-1:0] c,
                                                    input logic sat);
        logic [CNT_WIDTH-1:0] nxt;
        if (&c) nxt = sat ? c : '0;
        else    nxt = c + CNT_WIDTH'(1);
        cnt_step = {&c, nxt};
    endfunction

    logic [1:0]           ctrl, ctrl_n;
    logic [N_CNT-1:0]     ovf, ovf_n, ovf_ie, ovf_ie_n, ovf_set, ovf_clr;
    logic [N_CNT-1:0]     inc_p0, inc_p1;
    logic [SEL_W-1:0]     sel   [N_CNT];
    logic [SEL_W-1:0]     sel_n [N_CNT];
    logic [CNT_WIDTH-1:0] cnt   [N_CNT];
    logic [CNT_WIDTH-1:0] cnt_n [N_CNT];
    logic [HI_W-1:0]      hi_shadow, hi_shadow_n;

    logic [3:0] idx;
    logic       idx_ok, wr;
    logic       hit_ctrl, hit_ovf, hit_ie, hit_sel, hit_lo, hit_hi;

    assign idx      = csr_addr_i[3:0];
    assign idx_ok   = {1'b0, idx} < N_CNT_L;
    assign wr       = csr_op_i != OP_NONE;
    assign hit_ctrl = csr_access_i && (csr_addr_i == 12'h7A0);
    assign hit_ovf  = csr_access_i && (csr_addr_i == 12'h7A1);
    assign hit_ie   = csr_access_i && (csr_addr_i == 12'h7A2);
    assign hit_sel  = csr_access_i && (csr_addr_i[11:4] == 8'h7C) && idx_ok;
    assign hit_lo   = csr_access_i && (csr_addr_i[11:4] == 8'h78) && idx_ok;
    assign hit_hi   = csr_access_i && (csr_addr_i[11:4] == 8'h79) && idx_ok;
    assign csr_hit_o = hit_ctrl | hit_ovf | hit_ie | hit_sel | hit_lo | hit_hi;

    // Read mux: current register contents, high word always from the shadow.
    always_comb begin
        csr_rdata_o = '0;
        if (hit_ctrl) csr_rdata_o = {30'd0, ctrl};
        if (hit_ovf)  csr_rdata_o = 32'(ovf);
        if (hit_ie)   csr_rdata_o = 32'(ovf_ie);
        for (int i = 0; i < N_CNT; i++) begin
            if (idx == 4'(i)) begin
                if (hit_sel) csr_rdata_o = 32'(sel[i]);
                if (hit_lo)  csr_rdata_o = cnt[i][31:0];
            end
        end
        if (hit_hi) csr_rdata_o = 32'(hi_shadow);
    end

    // Event sampling: selected strobe gated by the global enable; selectors
    // outside the event bus never match.
    always_comb begin
        inc_p0 = '0;
        for (int i = 0; i < N_CNT; i++) begin
            for (int j = 0; j < N_EVENTS; j++) begin
                if (sel[i] == SEL_W'(j)) inc_p0[i] = events_i[j];
            end
            inc_p0[i] = inc_p0[i] & ctrl[0];
        end
    end

    // Next state: a CSR write to a counter beats its pending increment;
    // a new overflow beats a same-cycle write-1-to-clear.
    always_comb begin
        ovf_set     = '0;
        hi_shadow_n = hi_shadow;
        for (int i = 0; i < N_CNT; i++) begin
            cnt_n[i] = cnt[i];
            sel_n[i] = sel[i];
            if (idx == 4'(i) && hit_sel && wr)
                sel_n[i] = SEL_W'(csr_apply(csr_op_i, csr_wdata_i, 32'(sel[i])));
            if (idx == 4'(i) && hit_lo)
                hi_shadow_n = cnt[i][CNT_WIDTH-1:32];
            if (idx == 4'(i) && hit_lo && wr) begin
                cnt_n[i][31:0] = csr_apply(csr_op_i, csr_wdata_i, cnt[i][31:0]);
            end else if (idx == 4'(i) && hit_hi && wr) begin
                cnt_n[i][CNT_WIDTH-1:32] =
                    HI_W'(csr_apply(csr_op_i, csr_wdata_i, 32'(cnt[i][CNT_WIDTH-1:32])));
                hi_shadow_n = HI_W'(csr_apply(csr_op_i, csr_wdata_i, 32'(cnt[i][CNT_WIDTH-1:32])));
            end else if (inc_p1[i]) begin
                {ovf_set[i], cnt_n[i]} = cnt_step(cnt[i], ctrl[1]);
            end
        end
        ovf_clr  = (hit_ovf && (csr_op_i == OP_WRITE || csr_op_i == OP_SET))
                   ? csr_wdata_i[N_CNT-1:0] : '0;
        ovf_n    = (ovf & ~ovf_clr) | ovf_set;
        ctrl_n   = (hit_ctrl && wr) ? 2'(csr_apply(csr_op_i, csr_wdata_i, {30'd0, ctrl})) : ctrl;
        ovf_ie_n = (hit_ie && wr) ? N_CNT'(csr_apply(csr_op_i, csr_wdata_i, 32'(ovf_ie))) : ovf_ie;
    end

    // State registers; the increment pipeline is cleared by reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= 2'b01;
            ovf       <= '0;
            ovf_ie    <= '0;
            hi_shadow <= '0;
            inc_p1    <= '0;
            ovf_irq_o <= 1'b0;
            for (int i = 0; i < N_CNT; i++) begin
                sel[i] <= SEL_W'(i % N_EVENTS);
                cnt[i] <= '0;
            end
        end else begin
            ctrl      <= ctrl_n;
            ovf       <= ovf_n;
            ovf_ie    <= ovf_ie_n;
            hi_shadow <= hi_shadow_n;
            inc_p1    <= inc_p0;
            ovf_irq_o <= |(ovf_n & ovf_ie_n);
            for (int i = 0; i < N_CNT; i++) begin
                sel[i] <= sel_n[i];
                cnt[i] <= cnt_n[i];
            end
        end
    end

endmodule

// File: tb/tb_riscv_perf_counters_v2.sv
// Bench for riscv_perf_counters_v2: directed vector table, a reset-mid-count
// sequence, then randomized CSR traffic and events against a reference model.
module tb_riscv_perf_counters_v2;

    localparam int N_CNT     = 4;
    localparam int N_EVENTS  = 16;
    localparam int CNT_WIDTH = 48;
    localparam longint unsigned MAXV  = (64'd1 << CNT_WIDTH) - 1;
    localparam longint unsigned HMASK = (64'd1 << (CNT_WIDTH - 32)) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_access;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [15:0] events;
    logic        ovf_irq;

    always #5 clk = ~clk;

    riscv_perf_counters_v2 #(
        .N_CNT(N_CNT), .N_EVENTS(N_EVENTS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_access_i(csr_access), .csr_addr_i(csr_addr),
        .csr_wdata_i(csr_wdata), .csr_op_i(csr_op),
        .csr_rdata_o(csr_rdata), .csr_hit_o(csr_hit),
        .events_i(events), .ovf_irq_o(ovf_irq)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    longint unsigned m_cnt [N_CNT];
    int unsigned     m_sel [N_CNT];
    bit              m_en, m_sat, m_irq;
    bit [3:0]        m_ovf, m_ie, m_pend;
    longint unsigned m_shadow;

    function automatic void m_reset();
        for (int i = 0; i < N_CNT; i++) begin
            m_cnt[i] = 0;
            m_sel[i] = i % N_EVENTS;
        end
        m_en = 1; m_sat = 0; m_irq = 0;
        m_ovf = 0; m_ie = 0; m_pend = 0; m_shadow = 0;
    endfunction

    function automatic logic [31:0] m_apply(input logic [1:0] op, input logic [31:0] w,
                                            input logic [31:0] q);
        case (op)
            2'd1: return w;
            2'd2: return w | q;
            2'd3: return ~w & q;
            default: return q;
        endcase
    endfunction

    // kind: 0 none, 1 CTRL, 2 OVF, 3 OVF_IE, 4 SEL, 5 CNT_LO, 6 CNT_HI
    function automatic void m_decode(input logic acc, input logic [11:0] addr,
                                     output int kind, output int idx);
        int a;
        a = int'(addr);
        kind = 0; idx = 0;
        if (!acc) return;
        if (a == 'h7A0) kind = 1;
        else if (a == 'h7A1) kind = 2;
        else if (a == 'h7A2) kind = 3;
        else if (a >= 'h7C0 && a < 'h7C0 + N_CNT) begin kind = 4; idx = a - 'h7C0; end
        else if (a >= 'h780 && a < 'h780 + N_CNT) begin kind = 5; idx = a - 'h780; end
        else if (a >= 'h790 && a < 'h790 + N_CNT) begin kind = 6; idx = a - 'h790; end
    endfunction

    function automatic logic [31:0] m_read(input int kind, input int idx);
        case (kind)
            1: return {30'd0, m_sat, m_en};
            2: return 32'(m_ovf);
            3: return 32'(m_ie);
            4: return 32'(m_sel[idx]);
            5: return 32'(m_cnt[idx] & 64'hFFFF_FFFF);
            6: return 32'(m_shadow);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_update(input logic acc, input logic [1:0] op,
                                     input logic [11:0] addr, input logic [31:0] w,
                                     input logic [15:0] ev);
        int kind, idx;
        bit [3:0] set, npend;
        logic [31:0] v;
        longint unsigned hi;
        m_decode(acc, addr, kind, idx);
        set = 0; npend = 0;
        for (int i = 0; i < N_CNT; i++)
            if (m_en && m_sel[i] < N_EVENTS) npend[i] = ev[m_sel[i]];
        for (int i = 0; i < N_CNT; i++) begin
            if (kind == 5 && idx == i) m_shadow = m_cnt[i] >> 32;
            if ((kind == 5 || kind == 6) && idx == i && op != 0) begin
                if (kind == 5) begin
                    v = m_apply(op, w, 32'(m_cnt[i] & 64'hFFFF_FFFF));
                    m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(v);
                end else begin
                    v = m_apply(op, w, 32'(m_cnt[i] >> 32));
                    hi = 64'(v) & HMASK;
                    m_cnt[i] = (m_cnt[i] & 64'hFFFF_FFFF) | (hi << 32);
                    m_shadow = hi;
                end
            end else if (m_pend[i]) begin
                if (m_cnt[i] == MAXV) begin
                    set[i] = 1;
                    if (!m_sat) m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        if (kind == 2 && (op == 1 || op == 2)) m_ovf = m_ovf & ~w[3:0];
        m_ovf = m_ovf | set;
        if (kind == 1 && op != 0) begin
            v = m_apply(op, w, {30'd0, m_sat, m_en});
            m_en = v[0]; m_sat = v[1];
        end
        if (kind == 3 && op != 0) begin
            v = m_apply(op, w, 32'(m_ie));
            m_ie = v[3:0];
        end
        if (kind == 4 && op != 0) m_sel[idx] = m_apply(op, w, 32'(m_sel[idx])) & 31;
        m_irq = |(m_ovf & m_ie);
        m_pend = npend;
    endfunction

    // ---------------- drive / check ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, advance model.
    task automatic step(input logic acc, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] w, input logic [15:0] ev,
                        output logic [31:0] rd, output logic hit, output logic irq,
                        output logic [31:0] e_rd, output logic e_hit, output logic e_irq);
        int kind, idx;
        csr_access = acc; csr_op = op; csr_addr = addr; csr_wdata = w; events = ev;
        #1;
        rd = csr_rdata; hit = csr_hit; irq = ovf_irq;
        m_decode(acc, addr, kind, idx);
        e_hit = (kind != 0);
        e_rd  = m_read(kind, idx);
        e_irq = m_irq;
        m_update(acc, op, addr, w, ev);
        @(negedge clk);
    endtask

    typedef struct {
        logic        acc;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] w;
        logic [15:0] ev;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic        exp_irq;
        logic [95:0] name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic acc, input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] w, input logic [15:0] ev, input logic c,
                                input logic [31:0] rd, input logic hit, input logic irq,
                                input logic [95:0] name);
        vec_t v;
        v.acc = acc; v.op = op; v.addr = addr; v.w = w; v.ev = ev; v.chk = c;
        v.exp_rd = rd; v.exp_hit = hit; v.exp_irq = irq; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic void wr(input logic [11:0] addr, input logic [31:0] w);
        add(1, 2'd1, addr, w, 16'h0, 0, 0, 0, 0, "wr");
    endfunction

    function automatic void rdv(input logic [11:0] addr, input logic [31:0] exp,
                                input logic irq, input logic [95:0] name);
        add(1, 2'd0, addr, 0, 16'h0, 1, exp, 1, irq, name);
    endfunction

    function automatic void idle(input logic [15:0] ev);
        add(0, 2'd0, 12'h000, 0, ev, 0, 0, 0, 0, "idle");
    endfunction

    function automatic logic [11:0] rnd_addr();
        case ($urandom_range(0, 19))
            0: return 12'h7A0;  1: return 12'h7A1;  2: return 12'h7A2;  3: return 12'h7A3;
            4: return 12'h7C0;  5: return 12'h7C1;  6: return 12'h7C2;  7: return 12'h7C3;
            8: return 12'h7C4;  9: return 12'h780; 10: return 12'h781; 11: return 12'h782;
            12: return 12'h783; 13: return 12'h784; 14: return 12'h790; 15: return 12'h791;
            16: return 12'h792; 17: return 12'h793; 18: return 12'h794;
            default: return 12'(12'h700 + $urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, e_rd;
        logic hit, irq, e_hit, e_irq;
        logic [11:0] a;
        logic [31:0] w;

        csr_access = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; events = 0;
        rst_n = 0;
        m_reset();

        // reset values and decode
        rdv(12'h7C2, 2, 0, "sel2_rst");
        rdv(12'h7A0, 1, 0, "ctrl_rst");
        rdv(12'h780, 0, 0, "cnt0_rst");
        rdv(12'h7A1, 0, 0, "ovf_rst");
        add(0, 2'd0, 12'h7A0, 0, 16'h0, 1, 0, 0, 0, "no_access");
        add(1, 2'd0, 12'h7A3, 0, 16'h0, 1, 0, 0, 0, "hole_7a3");
        add(1, 2'd0, 12'h784, 0, 16'h0, 1, 0, 0, 0, "idx_oob");
        // SEL[1]=5, three pulses, 2-cycle visibility
        wr(12'h7C1, 5);
        add(1, 2'd0, 12'h781, 0, 16'h0020, 1, 0, 1, 0, "ev_pulse1");
        add(1, 2'd0, 12'h781, 0, 16'h0000, 1, 0, 1, 0, "ev_latency");
        add(1, 2'd0, 12'h781, 0, 16'h0020, 1, 1, 1, 0, "ev_visible");
        add(1, 2'd0, 12'h781, 0, 16'h0000, 1, 1, 1, 0, "ev_hold1");
        add(1, 2'd0, 12'h781, 0, 16'h0020, 1, 2, 1, 0, "ev_cnt2");
        add(1, 2'd0, 12'h781, 0, 16'h0000, 1, 2, 1, 0, "ev_hold2");
        rdv(12'h781, 3, 0, "cnt1_is3");
        rdv(12'h780, 0, 0, "cnt0_unch");
        rdv(12'h782, 0, 0, "cnt2_unch");
        rdv(12'h783, 0, 0, "cnt3_unch");
        // wrap overflow and interrupt
        wr(12'h780, 32'hFFFF_FFFF);
        wr(12'h790, 32'h0000_FFFF);
        wr(12'h7A2, 1);
        rdv(12'h790, 32'hFFFF, 0, "hi_wr_shadow");
        idle(16'h0001);
        rdv(12'h780, 32'hFFFF_FFFF, 0, "pre_wrap");
        rdv(12'h780, 0, 1, "wrapped_lo");
        rdv(12'h790, 0, 1, "wrapped_hi");
        rdv(12'h7A1, 1, 1, "ovf_set");
        add(1, 2'd1, 12'h7A1, 1, 16'h0, 1, 1, 1, 1, "ovf_w1c");
        rdv(12'h7A1, 0, 0, "irq_drop");
        // saturate mode
        wr(12'h7A0, 3);
        wr(12'h780, 32'hFFFF_FFFF);
        wr(12'h790, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) idle(16'h0001);
        idle(16'h0); idle(16'h0);
        rdv(12'h780, 32'hFFFF_FFFF, 1, "sat_lo");
        rdv(12'h790, 32'hFFFF, 1, "sat_hi");
        rdv(12'h7A1, 1, 1, "sat_ovf");
        wr(12'h7A1, 1);
        rdv(12'h7A1, 0, 0, "sat_ovf_clr");
        // atomic high-word read under continuous counting
        wr(12'h7A0, 1);
        wr(12'h780, 32'hFFFF_FFFF);
        wr(12'h790, 32'h0000_0001);
        idle(16'h0001);
        add(1, 2'd0, 12'h780, 0, 16'h0001, 1, 32'hFFFF_FFFF, 1, 0, "lo_first");
        idle(16'h0001);
        add(1, 2'd0, 12'h790, 0, 16'h0001, 1, 1, 1, 0, "hi_shadow");
        idle(16'h0);
        rdv(12'h780, 3, 0, "lo_after");
        rdv(12'h790, 2, 0, "hi_live");
        // write beats increment, CLEAR op, out-of-range selector
        idle(16'h0004);
        wr(12'h782, 32'h10);
        rdv(12'h782, 32'h10, 0, "wr_wins");
        wr(12'h782, 32'h13);
        add(1, 2'd3, 12'h782, 1, 16'h0, 0, 0, 0, 0, "clr");
        rdv(12'h782, 32'h12, 0, "clear_op");
        wr(12'h7C2, 16);
        rdv(12'h7C2, 16, 0, "sel_oob_rd");
        idle(16'hFFFF); idle(16'h0); idle(16'h0);
        rdv(12'h782, 32'h12, 0, "sel_oob_cnt");
        // overflow beats same-cycle W1C; masked bit raises no irq
        wr(12'h783, 32'hFFFF_FFFF);
        wr(12'h793, 32'h0000_FFFF);
        idle(16'h0008);
        add(1, 2'd1, 12'h7A1, 8, 16'h0, 1, 0, 1, 0, "w1c_vs_set");
        rdv(12'h7A1, 8, 0, "set_wins");
        // disable lands after an enabled sample: that event still counts
        add(1, 2'd1, 12'h7A0, 0, 16'h0008, 0, 0, 0, 0, "dis");
        idle(16'h0008);
        idle(16'h0);
        rdv(12'h783, 1, 0, "late_disable");
        wr(12'h7A0, 1);

        repeat (2) @(negedge clk);
        rst_n = 1;

        foreach (vecs[k]) begin
            step(vecs[k].acc, vecs[k].op, vecs[k].addr, vecs[k].w, vecs[k].ev,
                 rd, hit, irq, e_rd, e_hit, e_irq);
            if (vecs[k].chk) begin
                chk($sformatf("%0s_rd", vecs[k].name), rd, vecs[k].exp_rd);
                chk($sformatf("%0s_hit", vecs[k].name), {31'd0, hit}, {31'd0, vecs[k].exp_hit});
                chk($sformatf("%0s_irq", vecs[k].name), {31'd0, irq}, {31'd0, vecs[k].exp_irq});
            end
        end

        // reset pulse between edges while an increment is in flight
        step(0, 2'd0, 12'h0, 0, 16'h0001, rd, hit, irq, e_rd, e_hit, e_irq);
        #1 rst_n = 0;
        #1 rst_n = 1;
        m_reset();
        step(0, 2'd0, 12'h0, 0, 16'h0, rd, hit, irq, e_rd, e_hit, e_irq);
        step(1, 2'd0, 12'h780, 0, 16'h0, rd, hit, irq, e_rd, e_hit, e_irq);
        chk("rst_no_stray", rd, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        step(1, 2'd0, 12'h7C1, 0, 16'h0, rd, hit, irq, e_rd, e_hit, e_irq);
        chk("rst_sel1", rd, 32'h1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            a = rnd_addr();
            case ($urandom_range(0, 3))
                0: w = 32'hFFFF_FFFF;
                1: w = 32'($urandom_range(0, 20));
                default: w = $urandom;
            endcase
            if (a == 12'h7A0 && $urandom_range(0, 1) == 1) w = w | 32'h1;
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, w,
                 16'($urandom & $urandom), rd, hit, irq, e_rd, e_hit, e_irq);
            chk($sformatf("rnd%0d_rd@%h", n, a), rd, e_rd);
            chk($sformatf("rnd%0d_hit@%h", n, a), {31'd0, hit}, {31'd0, e_hit});
            chk($sformatf("rnd%0d_irq", n), {31'd0, irq}, {31'd0, e_irq});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_perf_counters_v2.md
Name: riscv_perf_counters_v2

Overview:
Parametrised hardware performance-monitor unit for the RI5CY core. It is the successor to the fixed 11-counter PCCR/PCER/PCMR scheme inside the CSR register file, and is instantiated beside it. It provides N_CNT counters with a programmable event selector per counter, widths up to 64 bits with an atomic high-word read, per-counter wrap/saturate overflow, and a maskable overflow interrupt. The CSR file forwards accesses in its address window and muxes csr_rdata_o when csr_hit_o is high.

Parameters:
N_CNT, 4, number of counters (1..16).
N_EVENTS, 16, width of the event input bus (2..32).
CNT_WIDTH, 48, counter width in bits (33..64).
EVT_SEL_W, $clog2(N_EVENTS), width of each event-selector field.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
csr_access_i  in  1  CSR access valid this cycle
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  CSR write operand
csr_op_i  in  2  NONE=0, WRITE=1, SET=2, CLEAR=3
csr_rdata_o  out  32  read data; 0 when no hit
csr_hit_o  out  1  address belongs to this unit (combinational)
events_i  in  N_EVENTS  single-cycle event strobes from the core
ovf_irq_o  out  1  registered overflow interrupt request

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low. All state below is flopped on clk and cleared by rst_n.
- Address map (hit requires csr_access_i):
  - 0x7A0 CTRL: bit0 = global enable, bit1 = saturate (1) / wrap (0).
  - 0x7A1 OVF: status, one bit per counter, write-1-to-clear for WRITE and SET. CLEAR op on OVF is ignored.
  - 0x7A2 OVF_IE: per-counter interrupt mask.
  - 0x7C0+i SEL[i]: event selector for counter i.
  - 0x780+i CNT_LO[i]: counter bits [31:0].
  - 0x790+i CNT_HI[i]: counter bits [CNT_WIDTH-1:32], zero-extended to 32 bits.
  - Addresses with i >= N_CNT: csr_hit_o=0.
- Reset values:
  - CTRL=2'b01; OVF=0; OVF_IE=0.
  - SEL[i] = i mod N_EVENTS; all counters 0.
  - HI shadow = 0; ovf_irq_o = 0.
- CSR op semantics (registers other than OVF):
  - new = WRITE: w; SET: w | q; CLEAR: ~w & q; NONE: no write.
  - Only implemented bits are stored; unimplemented bits read 0.
- Event pipeline:
  - inc_q[i] <= events_i[SEL[i]] & CTRL[0] & (SEL[i] < N_EVENTS).
  - The counter increments in the cycle after inc_q[i] is set, giving 2-cycle event-to-visible latency.
  - An event sampled while enabled still counts if CTRL[0] is cleared in the following cycle.
  - A SEL value >= N_EVENTS makes that counter count nothing.
- Overflow, when inc_q[i]=1 and the counter is all-ones:
  - Wrap mode: counter goes to 0 and OVF[i] is set.
  - Saturate mode: counter holds and OVF[i] is set.
  - OVF[i] is sticky until cleared.
- Interrupt: ovf_irq_o <= |(OVF_n & OVF_IE_n), i.e. it asserts one cycle after the overflow cycle.
- Atomic 64-bit read:
  - Any access to CNT_LO[i] (any op) latches counter[i] upper bits, before that cycle's update, into a single shared HI shadow.
  - A read of CNT_HI[i] returns the shadow, not the live value.
  - A write to CNT_HI[i] updates the live counter upper bits and the shadow.
  - The CNT_HI op operand for SET/CLEAR is the live value.
- Simultaneous events:
  - CSR write to CNT_LO/HI[i] in the same cycle as an increment: the write wins and the increment is lost. No overflow is flagged.
  - W1C of OVF[i] in the same cycle as a new overflow of i: set wins.
  - A CTRL write takes effect from the next cycle's event sampling.
- Reset mid-count clears inc_q, so no stray increment occurs after reset release.

Test Plan:
1. Reset, then read 0x7C2 -> 2; 0x7A0 -> 1; 0x780 -> 0; ovf_irq_o=0; csr_rdata_o=0 when csr_access_i=0.
2. SEL[1]=5, pulse events_i[5] for 3 single cycles -> CNT_LO[1] reads 3. The first increment is visible 2 cycles after the first pulse. Other counters are unchanged.
3. CNT_LO[0]=0xFFFF_FFFF, CNT_HI[0]=0xFFFF (CNT_WIDTH=48), wrap mode, OVF_IE=1, one event -> counter=0, OVF=1, ovf_irq_o high one cycle after. W1C OVF with 1 -> irq drops next cycle.
4. Same setup in saturate mode (CTRL=3) with 5 events -> counter stays all-ones (LO=0xFFFF_FFFF, HI=0xFFFF); OVF[0]=1.
5. CNT_LO=0xFFFF_FFFF, HI=0x0001, continuous events. Read LO, then read HI two cycles later -> HI returns 0x0001 (shadow) while the live value is 0x0002.
6. Write CNT_LO[2]=0x10 in the same cycle inc_q[2]=1 -> reads 0x10. A CLEAR op with w=0x1 on value 0x13 -> 0x12. SEL=N_EVENTS (out of range) -> no counting.
